// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: instruction field positions,
// instruction class codes and the bit each class takes in the one-hot class vector.
package decode_pkg;

   localparam int W_INSN     = 32;
   localparam int DOPC_WIDTH = 6;

   localparam int CLS_HI   = 31;
   localparam int CLS_LO   = 29;
   localparam int OPC_HI   = 28;
   localparam int OPC_LO   = 24;
   localparam int RD_HI    = 23;
   localparam int RD_LO    = 20;
   localparam int RS_HI    = 19;
   localparam int RS_LO    = 16;
   localparam int IMMF_BIT = 15;
   localparam int IMM_HI   = 14;
   localparam int IMM_LO   = 0;

   typedef enum logic [2:0] {
      CLS_INTE   = 3'd0,
      CLS_SHIFT  = 3'd1,
      CLS_LOGIC  = 3'd2,
      CLS_LOAD   = 3'd3,
      CLS_STORE  = 3'd4,
      CLS_BRANCH = 3'd5,
      CLS_ILL6   = 3'd6,
      CLS_ILL7   = 3'd7
   } cls_e;

   localparam int DOPC_INTE   = 5;
   localparam int DOPC_SHIFT  = 4;
   localparam int DOPC_LOGIC  = 3;
   localparam int DOPC_LOAD   = 2;
   localparam int DOPC_STORE  = 1;
   localparam int DOPC_BRANCH = 0;

   // Illegal classes map to all-zero; callers gate on legality separately.
   function automatic logic [DOPC_WIDTH-1:0] clsToDopc(input cls_e c);
      logic [DOPC_WIDTH-1:0] d;
      d = '0;
      case (c)
         CLS_INTE:   d[DOPC_INTE]   = 1'b1;
         CLS_SHIFT:  d[DOPC_SHIFT]  = 1'b1;
         CLS_LOGIC:  d[DOPC_LOGIC]  = 1'b1;
         CLS_LOAD:   d[DOPC_LOAD]   = 1'b1;
         CLS_STORE:  d[DOPC_STORE]  = 1'b1;
         CLS_BRANCH: d[DOPC_BRANCH] = 1'b1;
         default:    d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_reg_file.sv
// Architectural register file: two read ports, one write port, write-first
// bypass so a same-cycle read of the written index sees the new data.
module decode_reg_file #(
   parameter int WORD = 32,
   parameter int W_RD = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W_RD-1:0] i_rNumA,
   input  logic [W_RD-1:0] i_rNumB,
   output logic [WORD-1:0] o_rDataA,
   output logic [WORD-1:0] o_rDataB,
   input  logic            i_wEn,
   input  logic [W_RD-1:0] i_wNum,
   input  logic [WORD-1:0] i_wData
);

   logic [WORD-1:0] r_regs [2**W_RD];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2**W_RD; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_wEn) begin
         r_regs[i_wNum] <= i_wData;
      end
   end

   assign o_rDataA = (i_wEn && (i_wNum == i_rNumA)) ? i_wData : r_regs[i_rNumA];
   assign o_rDataB = (i_wEn && (i_wNum == i_rNumB)) ? i_wData : r_regs[i_rNumB];

endmodule

// File: rtl/decode.sv
// Instruction decode stage: splits the fetched word into class/opcode/operands,
// reads the register file and interlocks on the one-cycle EX writeback hazard.
module decode
   import decode_pkg::*;
#(
   parameter int WORD   = 32,
   parameter int ADDR   = 32,
   parameter int W_RD   = 4,
   parameter int W_OPC  = 5,
   parameter int W_DOPC = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              v_i,
   output logic              stall_o,
   input  logic [31:0]       insn_i,
   input  logic [ADDR-1:0]   addr_i,
   input  logic              stall_i,
   output logic              v_o,
   output logic [WORD-1:0]   src_o,
   output logic [WORD-1:0]   dest_o,
   output logic              wb_o,
   output logic [W_RD-1:0]   rd_num_o,
   output logic [W_DOPC-1:0] dopc_o,
   output logic [W_OPC-1:0]  opc_o,
   output logic [ADDR-1:0]   origaddr_o,
   input  logic              rf_wb_i,
   input  logic [W_RD-1:0]   rf_rd_num_i,
   input  logic [WORD-1:0]   rf_rd_data_i,
   output logic              illegal_o
);

   cls_e                 w_cls;
   logic [W_OPC-1:0]     w_opc;
   logic [W_RD-1:0]      w_rd;
   logic [W_RD-1:0]      w_rs;
   logic                 w_immf;
   logic [IMM_HI:IMM_LO] w_imm;
   logic [WORD-1:0]      w_sext;
   logic [WORD-1:0]      w_rsData;
   logic [WORD-1:0]      w_rdData;
   logic                 w_legal;
   logic                 w_wb;
   logic                 w_hazard;

   logic                 r_v;
   logic                 r_wb;
   logic [WORD-1:0]      r_src;
   logic [WORD-1:0]      r_dest;
   logic [W_RD-1:0]      r_rdNum;
   logic [W_DOPC-1:0]    r_dopc;
   logic [W_OPC-1:0]     r_opc;
   logic [ADDR-1:0]      r_origAddr;
   logic                 r_illegal;

   assign w_cls  = cls_e'(insn_i[CLS_HI:CLS_LO]);
   assign w_opc  = insn_i[OPC_HI:OPC_LO];
   assign w_rd   = insn_i[RD_HI:RD_LO];
   assign w_rs   = insn_i[RS_HI:RS_LO];
   assign w_immf = insn_i[IMMF_BIT];
   assign w_imm  = insn_i[IMM_HI:IMM_LO];
   assign w_sext = {{(WORD-(IMM_HI+1)){w_imm[IMM_HI]}}, w_imm};

   assign w_legal = (w_cls != CLS_ILL6) && (w_cls != CLS_ILL7);
   assign w_wb    = (w_cls == CLS_INTE) || (w_cls == CLS_SHIFT) ||
                    (w_cls == CLS_LOGIC) || (w_cls == CLS_LOAD);

   // rd is compared unconditionally because store and branch also read it.
   assign w_hazard = v_i && r_v && r_wb && w_legal &&
                     ((r_rdNum == w_rd) || (!w_immf && (r_rdNum == w_rs)));

   assign stall_o = stall_i || w_hazard;

   decode_reg_file #(
      .WORD (WORD),
      .W_RD (W_RD)
   ) u_regFile (
      .clk      (clk),
      .rst      (rst),
      .i_rNumA  (w_rs),
      .i_rNumB  (w_rd),
      .o_rDataA (w_rsData),
      .o_rDataB (w_rdData),
      .i_wEn    (rf_wb_i),
      .i_wNum   (rf_rd_num_i),
      .i_wData  (rf_rd_data_i)
   );

   // Bubbles clear only v/wb; the data fields keep their last values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_v        <= 1'b0;
         r_wb       <= 1'b0;
         r_src      <= '0;
         r_dest     <= '0;
         r_rdNum    <= '0;
         r_dopc     <= '0;
         r_opc      <= '0;
         r_origAddr <= '0;
         r_illegal  <= 1'b0;
      end else if (stall_i) begin
         r_v <= r_v;
      end else if (w_hazard || !v_i) begin
         r_v  <= 1'b0;
         r_wb <= 1'b0;
      end else if (!w_legal) begin
         r_v       <= 1'b0;
         r_wb      <= 1'b0;
         r_illegal <= 1'b1;
      end else begin
         r_v        <= 1'b1;
         r_wb       <= w_wb;
         r_src      <= w_immf ? w_sext : w_rsData;
         r_dest     <= w_rdData;
         r_rdNum    <= w_rd;
         r_dopc     <= clsToDopc(w_cls);
         r_opc      <= w_opc;
         r_origAddr <= addr_i;
      end
   end

   assign v_o        = r_v;
   assign wb_o       = r_wb;
   assign src_o      = r_src;
   assign dest_o     = r_dest;
   assign rd_num_o   = r_rdNum;
   assign dopc_o     = r_dopc;
   assign opc_o      = r_opc;
   assign origaddr_o = r_origAddr;
   assign illegal_o  = r_illegal;

endmodule
